// File: rtl/cast_source_ctrl.sv
// Deadlock-check harness: injects a flit stream at the source node, counts
// flits returned at the sink, and reports done or hang via a watchdog.
`ifndef DW
`define DW 32
`endif

module cast_source_ctrl #(
  parameter int NUM_FLITS   = 10000,
  parameter int TIMEOUT     = 1024,
  parameter int CW          = 32,
  parameter bit CHECK_ORDER = 1'b0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start_i,
  output logic [`DW-1:0] src_data_o,
  output logic           src_valid_o,
  input  logic           src_ready_i,
  input  logic [`DW-1:0] snk_data_i,
  input  logic           snk_valid_i,
  output logic           snk_ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           hang_o,
  output logic           err_o,
  output logic [CW-1:0]  sent_cnt_o,
  output logic [CW-1:0]  recv_cnt_o
);

  localparam int DW = `DW;
  localparam logic [CW-1:0] NF     = CW'(NUM_FLITS);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_HANG
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] sent_cnt, sent_d;
  logic [CW-1:0] recv_cnt, recv_d;
  logic [CW-1:0] wd, wd_d;
  logic          err, err_d;
  logic          active;
  logic          src_hs, snk_hs, any_hs;
  logic          bad_data;

  assign active      = (state == S_RUN) || (state == S_DRAIN);
  assign src_valid_o = (state == S_RUN);
  assign snk_ready_o = active && (recv_cnt < NF);
  assign src_hs      = src_valid_o & src_ready_i;
  assign snk_hs      = snk_valid_i & snk_ready_o;
  assign any_hs      = src_hs | snk_hs;
  assign bad_data    = CHECK_ORDER && (snk_data_i != DW'(recv_cnt));

  assign src_data_o = DW'(sent_cnt);
  assign busy_o     = active;
  assign done_o     = (state == S_DONE);
  assign hang_o     = (state == S_HANG);
  assign err_o      = err;
  assign sent_cnt_o = sent_cnt;
  assign recv_cnt_o = recv_cnt;

  always_comb begin
    state_d = state;
    sent_d  = sent_cnt;
    recv_d  = recv_cnt;
    wd_d    = wd;
    err_d   = err;
    unique case (state)
      S_IDLE, S_DONE, S_HANG: begin
        if (start_i) begin
          state_d = S_RUN;
          sent_d  = '0;
          recv_d  = '0;
          wd_d    = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN, S_DRAIN: begin
        sent_d = sent_cnt + CW'(src_hs);
        recv_d = recv_cnt + CW'(snk_hs);
        wd_d   = any_hs ? '0 : wd + 1'b1;
        if (snk_hs && bad_data) err_d = 1'b1;
        // a silent cycle can only end in HANG; completion needs a handshake
        if (!any_hs && (wd == WD_MAX)) begin
          state_d = S_HANG;
        end else if ((sent_d == NF) && (recv_d == NF)) begin
          state_d = S_DONE;
        end else if ((state == S_RUN) && (sent_d == NF)) begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      sent_cnt <= '0;
      recv_cnt <= '0;
      wd       <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      sent_cnt <= sent_d;
      recv_cnt <= recv_d;
      wd       <= wd_d;
      err      <= err_d;
    end
  end

endmodule
